// File: rtl/pc_fetch_unit.sv
// PC / instruction-register stage: holds PC, fetches instruction words over req/ack, stalls the control unit.
// Optional single-entry prefetch buffer enabled by defining PCU_PREFETCH_EN.
module pc_fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            il_in,
  input  logic [1:0]      ps_in,
  input  logic [15:0]     ir_in,
  input  logic [PC_W-1:0] a_in,
  output logic            imem_req_out,
  output logic [PC_W-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [15:0]     imem_data_in,
  output logic [15:0]     ins_out,
  output logic [PC_W-1:0] pc_out,
  output logic            stall_out
);

  localparam int unsigned IW    = 16;
  localparam int unsigned OFF_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWAIT = 2'd1,
    PWAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
  logic            ir_load;
  logic            demand;
  logic [OFF_W-1:0] br_off;
  logic [PC_W-1:0]  br_off_ext;
  logic [PC_W-1:0]  pc_inc;

  // Branch offset lives in the IR, so the control unit's ir_in copy is redundant.
  logic unused_ir;
  assign unused_ir = ^ir_in;

  assign br_off     = {ir_q[8:6], ir_q[2:0]};
  assign br_off_ext = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};
  assign pc_inc     = pc_q + PC_W'(1);

`ifdef PCU_PREFETCH_EN
  logic            buf_valid_q, buf_valid_d;
  logic [PC_W-1:0] buf_addr_q, buf_addr_d;
  logic [IW-1:0]   buf_data_q, buf_data_d;
  logic            buf_hit;

  assign buf_hit = buf_valid_q && (buf_addr_q == pc_q);
`endif

  // Next PC; only committed when no instruction load is requested.
  always_comb begin
    pc_d = pc_q;
    case (ps_in)
      2'b01:   pc_d = pc_inc;
      2'b10:   pc_d = pc_q + br_off_ext;
      2'b11:   pc_d = a_in;
      default: pc_d = pc_q;
    endcase
  end

  // Fetch FSM next-state, request and IR-load decode.
  always_comb begin
    state_d       = state_q;
    imem_req_out  = 1'b0;
    imem_addr_out = pc_q;
    ir_load       = 1'b0;
    ir_d          = imem_data_in;
    fetch_addr_d  = fetch_addr_q;
    demand        = 1'b0;
`ifdef PCU_PREFETCH_EN
    buf_valid_d   = buf_valid_q;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
`endif
    case (state_q)
      IDLE: begin
        demand = il_in;
`ifdef PCU_PREFETCH_EN
        if (il_in) begin
          buf_valid_d = 1'b0;
          if (buf_hit) begin
            demand  = 1'b0;
            ir_load = 1'b1;
            ir_d    = buf_data_q;
          end
        end else if (!buf_valid_q) begin
          imem_req_out  = 1'b1;
          imem_addr_out = pc_inc;
          fetch_addr_d  = pc_inc;
          if (imem_ack_in) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = pc_inc;
            buf_data_d  = imem_data_in;
          end else begin
            state_d = PWAIT;
          end
        end
`endif
        if (demand) begin
          imem_req_out = 1'b1;
          fetch_addr_d = pc_q;
          if (imem_ack_in) ir_load = 1'b1;
          else             state_d = DWAIT;
        end
      end
      DWAIT: begin
        imem_req_out  = 1'b1;
        imem_addr_out = fetch_addr_q;
        if (imem_ack_in) begin
          ir_load = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef PCU_PREFETCH_EN
      PWAIT: begin
        imem_req_out  = 1'b1;
        imem_addr_out = fetch_addr_q;
        if (imem_ack_in) begin
          state_d = IDLE;
          if (il_in) begin
            // Matching prefetch doubles as the demand response; otherwise drop it and refetch from IDLE.
            if (fetch_addr_q == pc_q) ir_load = 1'b1;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = fetch_addr_q;
            buf_data_d  = imem_data_in;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign stall_out = il_in & ~ir_load;
  assign ins_out   = ir_q;
  assign pc_out    = pc_q;

  // State, PC and IR registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      fetch_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      if (ir_load) ir_q <= ir_d;
      if (!il_in)  pc_q <= pc_d;
    end
  end

`ifdef PCU_PREFETCH_EN
  // Prefetch buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= RESET_PC;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (default build): reset, fetch latency, PC select, wrap, reset mid-fetch.
module tb_pc_fetch_unit;

  localparam int unsigned PC_W = 16;

  logic            clk;
  logic            rst;
  logic            il_in;
  logic [1:0]      ps_in;
  logic [15:0]     ir_in;
  logic [PC_W-1:0] a_in;
  logic            imem_req_out;
  logic [PC_W-1:0] imem_addr_out;
  logic            imem_ack_in;
  logic [15:0]     imem_data_in;
  logic [15:0]     ins_out;
  logic [PC_W-1:0] pc_out;
  logic            stall_out;

  logic [15:0] mem [0:255];
  int checks;
  int errors;

  pc_fetch_unit #(.PC_W(PC_W), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .il_in         (il_in),
    .ps_in         (ps_in),
    .ir_in         (ir_in),
    .a_in          (a_in),
    .imem_req_out  (imem_req_out),
    .imem_addr_out (imem_addr_out),
    .imem_ack_in   (imem_ack_in),
    .imem_data_in  (imem_data_in),
    .ins_out       (ins_out),
    .pc_out        (pc_out),
    .stall_out     (stall_out)
  );

  assign imem_data_in = mem[imem_addr_out[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    mem[4] = 16'hBEEF;
    mem[5] = 16'h01C6;   // offset field {111,110} = -2
    rst = 1'b1; il_in = 1'b0; ps_in = 2'b00; ir_in = '0; a_in = '0; imem_ack_in = 1'b0;

    // Reset held two cycles
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_pc",    32'(pc_out),        32'h0000);
    chk("rst_ins",   32'(ins_out),       32'h0000);
    chk("rst_req",   32'(imem_req_out),  32'h0);
    chk("rst_stall", 32'(stall_out),     32'h0);
    chk("rst_addr",  32'(imem_addr_out), 32'h0000);

    // Zero-wait fetch
    il_in = 1'b1; imem_ack_in = 1'b1;
    #1;
    chk("zw_req",   32'(imem_req_out),  32'h1);
    chk("zw_addr",  32'(imem_addr_out), 32'h0000);
    chk("zw_stall", 32'(stall_out),     32'h0);
    tick();
    il_in = 1'b0; imem_ack_in = 1'b0;
    #1;
    chk("zw_ins",   32'(ins_out),   32'h1234);
    chk("zw_pc",    32'(pc_out),    32'h0000);
    chk("zw_stall2",32'(stall_out), 32'h0);

    // Jump to 5
    ps_in = 2'b11; a_in = 16'h0005;
    tick();
    ps_in = 2'b00;
    #1;
    chk("jmp5_pc", 32'(pc_out), 32'h0005);

    // 3-cycle latency fetch of mem[5]
    il_in = 1'b1;
    #1;
    chk("lat_c1_stall", 32'(stall_out),     32'h1);
    chk("lat_c1_req",   32'(imem_req_out),  32'h1);
    chk("lat_c1_addr",  32'(imem_addr_out), 32'h0005);
    tick();
    chk("lat_c2_stall", 32'(stall_out),     32'h1);
    chk("lat_c2_addr",  32'(imem_addr_out), 32'h0005);
    chk("lat_c2_ins",   32'(ins_out),       32'h1234);
    tick();
    imem_ack_in = 1'b1;
    #1;
    chk("lat_c3_stall", 32'(stall_out),     32'h0);
    chk("lat_c3_addr",  32'(imem_addr_out), 32'h0005);
    chk("lat_c3_req",   32'(imem_req_out),  32'h1);
    tick();
    il_in = 1'b0; imem_ack_in = 1'b0;
    #1;
    chk("lat_ins",   32'(ins_out),      32'h01C6);
    chk("lat_req",   32'(imem_req_out), 32'h0);
    chk("lat_stall", 32'(stall_out),    32'h0);
    chk("lat_pc",    32'(pc_out),       32'h0005);

    // Relative branch by -2
    ps_in = 2'b10;
    tick();
    ps_in = 2'b00;
    #1;
    chk("br_neg_pc", 32'(pc_out), 32'h0003);
    tick();
    chk("hold_pc", 32'(pc_out), 32'h0003);

    // Jump to 0xFFFF then increment wraps to 0
    ps_in = 2'b11; a_in = 16'hFFFF;
    tick();
    chk("jmp_ffff_pc", 32'(pc_out), 32'hFFFF);
    ps_in = 2'b01;
    tick();
    ps_in = 2'b00;
    #1;
    chk("inc_wrap_pc", 32'(pc_out), 32'h0000);

    // il_in has priority over ps_in
    il_in = 1'b1; imem_ack_in = 1'b1; ps_in = 2'b01;
    #1;
    chk("pri_stall", 32'(stall_out), 32'h0);
    tick();
    il_in = 1'b0; imem_ack_in = 1'b0; ps_in = 2'b00;
    #1;
    chk("pri_pc",  32'(pc_out),  32'h0000);
    chk("pri_ins", 32'(ins_out), 32'h1234);

    // Forward branch: IR 0x1234 gives offset +4
    ps_in = 2'b10;
    tick();
    ps_in = 2'b00;
    #1;
    chk("br_pos_pc", 32'(pc_out), 32'h0004);

    // Reset during DWAIT, late ack afterwards
    il_in = 1'b1;
    tick();
    chk("mid_req",   32'(imem_req_out),  32'h1);
    chk("mid_stall", 32'(stall_out),     32'h1);
    chk("mid_addr",  32'(imem_addr_out), 32'h0004);
    rst = 1'b1;
    tick();
    rst = 1'b0; il_in = 1'b0; imem_ack_in = 1'b1;
    #1;
    chk("mid_req_after_rst", 32'(imem_req_out), 32'h0);
    tick();
    imem_ack_in = 1'b0;
    #1;
    chk("mid_ins",   32'(ins_out),      32'h0000);
    chk("mid_pc",    32'(pc_out),       32'h0000);
    chk("mid_req2",  32'(imem_req_out), 32'h0);
    chk("mid_stall2",32'(stall_out),    32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
